mc_ctrl: RTL and testbench

- Multi-cycle control unit for the next-generation MIPS core. It replaces the single-cycle combinational decoder with an FSM that sequences a shared datapath through FETCH/DECODE/EXEC/MEM/WB.
- Drives the same control bundle as the existing controller, plus PC/IR write enables, a memory handshake and a retire pulse.
- Sits beside datapath inside mips. It takes opcode, func and zero from the IR/ALU and sends control signals back.

---
 rtl/mc_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control unit.
// Sequences the shared datapath through FETCH/DECODE/EXEC/MEM/WB and drives
// the control bundle back to it.
//   clk, reset           : clock, synchronous active-high reset
//   opcode, func, zero   : IR fields and ALU equal flag from the datapath
//   mem_ready            : memory access completes this cycle
//   PCWR, IRWR, RFWR     : PC / IR / register-file write enables
//   DMWR, mem_req        : data-memory write enable, memory request
//   ALUOP, NPCOP, EXTOP  : ALU op, next-PC source, immediate extension
//   WRSEL, WDSEL, BSEL   : RF write address / data source, ALU B source
//   state                : current FSM state (debug)
//   retire, instr_cnt    : final-cycle pulse and retired-instruction count
module mc_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       func,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWR,
    output logic             IRWR,
    output logic             RFWR,
    output logic             DMWR,
    output logic             mem_req,
    output logic [2:0]       ALUOP,
    output logic [2:0]       NPCOP,
    output logic [1:0]       EXTOP,
    output logic [1:0]       WRSEL,
    output logic [1:0]       WDSEL,
    output logic             BSEL,
    output logic [2:0]       state,
    output logic             retire,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_OR   = 3'd2;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

    logic is_rtype, is_addu, is_subu, is_jr, is_j, is_jal, is_beq;
    logic is_ori, is_lui, is_lw, is_sw, needs_exec;
    logic [2:0] x_aluop;
    logic [1:0] x_extop;
    logic       x_bsel;

    assign is_rtype   = (opcode == OP_RTYPE);
    assign is_addu    = is_rtype && (func == FN_ADDU);
    assign is_subu    = is_rtype && (func == FN_SUBU);
    assign is_jr      = is_rtype && (func == FN_JR);
    assign is_j       = (opcode == OP_J);
    assign is_jal     = (opcode == OP_JAL);
    assign is_beq     = (opcode == OP_BEQ);
    assign is_ori     = (opcode == OP_ORI);
    assign is_lui     = (opcode == OP_LUI);
    assign is_lw      = (opcode == OP_LW);
    assign is_sw      = (opcode == OP_SW);
    assign needs_exec = is_addu || is_subu || is_beq || is_ori || is_lui || is_lw || is_sw;

    // EXEC-phase datapath selects; reused unchanged in MEM and WB so the
    // ALU result and extended immediate stay stable across those states.
    always_comb begin
        x_aluop = ALU_ADD;
        x_extop = 2'd0;
        x_bsel  = 1'b0;
        if (is_subu || is_beq) begin
            x_aluop = ALU_SUB;
        end else if (is_ori || is_lui) begin
            x_aluop = ALU_OR;
        end
        if (is_ori || is_lui || is_lw || is_sw) begin
            x_bsel = 1'b1;
        end
        if (is_lui) begin
            x_extop = 2'd2;
        end else if (is_lw || is_sw) begin
            x_extop = 2'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        PCWR    = 1'b0;
        IRWR    = 1'b0;
        RFWR    = 1'b0;
        DMWR    = 1'b0;
        mem_req = 1'b0;
        retire  = 1'b0;
        ALUOP   = ALU_ADD;
        NPCOP   = 3'd0;
        EXTOP   = 2'd0;
        WRSEL   = 2'd0;
        WDSEL   = 2'd0;
        BSEL    = 1'b0;

        unique case (state_q)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    IRWR    = 1'b1;
                    PCWR    = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (is_j || is_jal) begin
                    PCWR    = 1'b1;
                    NPCOP   = 3'd2;
                    retire  = 1'b1;
                    state_d = FETCH;
                    if (is_jal) begin
                        RFWR  = 1'b1;
                        WRSEL = 2'd2;
                        WDSEL = 2'd2;
                    end
                end else if (is_jr) begin
                    PCWR    = 1'b1;
                    NPCOP   = 3'd3;
                    retire  = 1'b1;
                    state_d = FETCH;
                end else if (needs_exec) begin
                    state_d = EXEC;
                end else begin
                    // Unrecognised encodings retire as a nop.
                    retire  = 1'b1;
                    state_d = FETCH;
                end
            end
            EXEC: begin
                ALUOP = x_aluop;
                EXTOP = x_extop;
                BSEL  = x_bsel;
                if (is_beq) begin
                    PCWR    = zero;
                    NPCOP   = 3'd1;
                    retire  = 1'b1;
                    state_d = FETCH;
                end else if (is_lw || is_sw) begin
                    state_d = MEM;
                end else if (needs_exec) begin
                    state_d = WB;
                end else begin
                    state_d = FETCH;
                end
            end
            MEM: begin
                mem_req = 1'b1;
                ALUOP   = x_aluop;
                EXTOP   = x_extop;
                BSEL    = x_bsel;
                if (mem_ready) begin
                    if (is_sw) begin
                        DMWR    = 1'b1;
                        retire  = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end
            end
            WB: begin
                ALUOP   = x_aluop;
                EXTOP   = x_extop;
                BSEL    = x_bsel;
                RFWR    = 1'b1;
                WRSEL   = is_rtype ? 2'd1 : 2'd0;
                WDSEL   = is_lw ? 2'd1 : 2'd0;
                retire  = 1'b1;
                state_d = FETCH;
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        // Reset masks every enable and select so an aborted instruction
        // cannot write anything in the reset cycle.
        if (reset) begin
            state_d = FETCH;
            PCWR    = 1'b0;
            IRWR    = 1'b0;
            RFWR    = 1'b0;
            DMWR    = 1'b0;
            mem_req = 1'b0;
            retire  = 1'b0;
            ALUOP   = ALU_ADD;
            NPCOP   = 3'd0;
            EXTOP   = 2'd0;
            WRSEL   = 2'd0;
            WDSEL   = 2'd0;
            BSEL    = 1'b0;
        end
    end

    always_comb begin
        instr_cnt_d = instr_cnt_q + CNT_W'(retire);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FETCH;
            instr_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign state     = state_q;
    assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: self-checking bench for mc_ctrl (instantiated with a 4-bit
// retire counter so wrap-around is reached quickly).
module tb_mc_ctrl;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [5:0]    opcode, func;
    logic          zero, mem_ready;
    logic          PCWR, IRWR, RFWR, DMWR, mem_req, BSEL, retire;
    logic [2:0]    ALUOP, NPCOP, state;
    logic [1:0]    EXTOP, WRSEL, WDSEL;
    logic [CW-1:0] instr_cnt;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned exp_cnt = 0;
    logic        rdy_seq [64];

    mc_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .func(func), .zero(zero),
        .mem_ready(mem_ready), .PCWR(PCWR), .IRWR(IRWR), .RFWR(RFWR),
        .DMWR(DMWR), .mem_req(mem_req), .ALUOP(ALUOP), .NPCOP(NPCOP),
        .EXTOP(EXTOP), .WRSEL(WRSEL), .WDSEL(WDSEL), .BSEL(BSEL),
        .state(state), .retire(retire), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    // Per-instruction expectations, straight from the instruction table.
    typedef struct {
        bit         has_e, has_m, has_w;
        int         pcwr_n, rfwr_n, dmwr_n;
        logic [1:0] wrsel, wdsel;
        logic [2:0] npc_jmp;
        logic [2:0] aluop;
        logic [1:0] extop;
        logic       bsel;
    } exp_t;

    function automatic exp_t expect_of(input logic [5:0] op, input logic [5:0] fn, input logic z);
        exp_t e;
        e = '{has_e: 0, has_m: 0, has_w: 0, pcwr_n: 1, rfwr_n: 0, dmwr_n: 0,
              wrsel: 0, wdsel: 0, npc_jmp: 0, aluop: 0, extop: 0, bsel: 0};
        case (op)
            6'b000000: begin
                if (fn == 6'b100001 || fn == 6'b100011) begin
                    e.has_e = 1; e.has_w = 1; e.rfwr_n = 1; e.wrsel = 1;
                    e.aluop = (fn == 6'b100011) ? 3'd1 : 3'd0;
                end else if (fn == 6'b001000) begin
                    e.pcwr_n = 2; e.npc_jmp = 3;
                end
            end
            6'b000010: begin e.pcwr_n = 2; e.npc_jmp = 2; end
            6'b000011: begin e.pcwr_n = 2; e.npc_jmp = 2; e.rfwr_n = 1; e.wrsel = 2; e.wdsel = 2; end
            6'b000100: begin e.has_e = 1; e.pcwr_n = 1 + int'(z); e.npc_jmp = 1; e.aluop = 1; end
            6'b001101: begin e.has_e = 1; e.has_w = 1; e.rfwr_n = 1; e.aluop = 2; e.bsel = 1; end
            6'b001111: begin e.has_e = 1; e.has_w = 1; e.rfwr_n = 1; e.aluop = 2; e.extop = 2; e.bsel = 1; end
            6'b100011: begin e.has_e = 1; e.has_m = 1; e.has_w = 1; e.rfwr_n = 1; e.wdsel = 1; e.extop = 1; e.bsel = 1; end
            6'b101011: begin e.has_e = 1; e.has_m = 1; e.dmwr_n = 1; e.extop = 1; e.bsel = 1; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic logic rdy_at(input int unsigned k);
        return (k < 64) ? rdy_seq[k] : 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Called just after a negedge with the DUT in FETCH. Returns just after
    // the negedge following the retire cycle.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        exp_t        e;
        logic [2:0]  phases[$];
        logic [2:0]  exp_st[$];
        int unsigned k, cyc;
        int          n_pc, n_ir, n_rf, n_dm;
        bit          done;
        e = expect_of(op, fn, z);
        phases = '{3'd0, 3'd1};
        if (e.has_e) phases.push_back(3'd2);
        if (e.has_m) phases.push_back(3'd3);
        if (e.has_w) phases.push_back(3'd4);
        k = 0;
        foreach (phases[i]) begin
            if (phases[i] == 3'd0 || phases[i] == 3'd3) begin
                while (!rdy_at(k)) begin
                    exp_st.push_back(phases[i]);
                    k++;
                end
            end
            exp_st.push_back(phases[i]);
            k++;
        end

        opcode = op; func = fn; zero = z;
        cyc = 0; done = 0; n_pc = 0; n_ir = 0; n_rf = 0; n_dm = 0;
        while (!done && cyc < 80) begin
            mem_ready = rdy_at(cyc);
            #1;
            if (cyc < exp_st.size()) begin
                chk("state", 32'(state), 32'(exp_st[cyc]));
                chk("mem_req", 32'(mem_req), 32'(exp_st[cyc] == 3'd0 || exp_st[cyc] == 3'd3));
            end
            if (PCWR) n_pc++;
            if (IRWR) n_ir++;
            if (DMWR) n_dm++;
            if (IRWR) chk("fetch_npcop", 32'(NPCOP), 0);
            if (PCWR && !IRWR) chk("jump_npcop", 32'(NPCOP), 32'(e.npc_jmp));
            if (RFWR) begin
                n_rf++;
                chk("wrsel", 32'(WRSEL), 32'(e.wrsel));
                chk("wdsel", 32'(WDSEL), 32'(e.wdsel));
            end
            if (retire) begin
                done = 1;
                chk("aluop", 32'(ALUOP), 32'(e.aluop));
                chk("extop", 32'(EXTOP), 32'(e.extop));
                chk("bsel", 32'(BSEL), 32'(e.bsel));
            end
            @(negedge clk);
            cyc++;
        end
        chk("cycles", cyc, exp_st.size());
        chk("pcwr_pulses", n_pc, e.pcwr_n);
        chk("irwr_pulses", n_ir, 1);
        chk("rfwr_pulses", n_rf, e.rfwr_n);
        chk("dmwr_pulses", n_dm, e.dmwr_n);
        exp_cnt = (exp_cnt + 1) % (1 << CW);
        chk("instr_cnt", 32'(instr_cnt), exp_cnt);
    endtask

    task automatic all_ready();
        foreach (rdy_seq[i]) rdy_seq[i] = 1'b1;
    endtask

    initial begin
        logic [5:0] op_tab [12];
        logic [5:0] fn_tab [12];
        int unsigned sel;
        op_tab = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000010, 6'b000011,
                   6'b000100, 6'b001101, 6'b001111, 6'b100011, 6'b101011, 6'b111111};
        fn_tab = '{6'b100001, 6'b100011, 6'b001000, 6'b100101, 6'b000000, 6'b000000,
                   6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000};

        // Reset held for three cycles with memory ready and an ori in IR.
        reset = 1'b1; mem_ready = 1'b1; opcode = 6'b001101; func = 6'b0; zero = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("reset_enables", 32'({PCWR, IRWR, RFWR, DMWR, mem_req, retire}), 0);
            chk("reset_npcop", 32'(NPCOP), 0);
            chk("reset_state", 32'(state), 0);
            chk("reset_cnt", 32'(instr_cnt), 0);
            @(negedge clk);
        end
        reset = 1'b0;
        exp_cnt = 0;

        all_ready();
        run_instr(6'b001101, 6'b0, 1'b0);             // ori: 0,1,2,4

        all_ready();
        rdy_seq[3] = 1'b0; rdy_seq[4] = 1'b0; rdy_seq[5] = 1'b0;
        run_instr(6'b100011, 6'b0, 1'b0);             // lw, 3 stalls in MEM

        all_ready();
        run_instr(6'b000100, 6'b0, 1'b1);             // beq taken
        run_instr(6'b000100, 6'b0, 1'b0);             // beq not taken
        run_instr(6'b000011, 6'b0, 1'b0);             // jal
        run_instr(6'b000000, 6'b001000, 1'b0);        // jr
        run_instr(6'b101011, 6'b0, 1'b0);             // sw
        run_instr(6'b111111, 6'b0, 1'b0);             // undefined opcode

        // Reset in the MEM cycle of a sw with memory ready.
        all_ready();
        opcode = 6'b101011; func = 6'b0; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_dmwr", 32'(DMWR), 0);
        chk("abort_retire", 32'(retire), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_state", 32'(state), 0);
        chk("abort_cnt", 32'(instr_cnt), 0);
        @(negedge clk);
        // One idle FETCH elapsed with mem_ready=1: that fetch went to DECODE,
        // so restart cleanly with a reset cycle.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_cnt = 0;

        // Random instruction mix with random memory stalls; >16 retires
        // wrap the 4-bit counter.
        for (int n = 0; n < 40; n++) begin
            foreach (rdy_seq[i]) rdy_seq[i] = ($urandom_range(0, 2) != 0);
            sel = $urandom_range(0, 11);
            run_instr(op_tab[sel], fn_tab[sel], 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
